// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: decode, load-use, branch flush and memory-freeze control
// for the five-stage core. Drives the PC mux and every pipeline-register enable.
// Optional performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned MEM_LAT     = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [31:0]       id_inst_i,
  input  logic              ex_memread_i,
  input  logic [4:0]        ex_rd_i,
  input  logic              mem_access_i,
  input  logic              branch_taken_i,
  output logic [2:0]        opcode_o,
  output logic              valid_o,
  output logic              pc_write_o,
  output logic              pc_sel_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              pipe_en_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_MEM_WAIT
  } state_e;

  localparam bit       FREEZE_EN    = (MEM_LAT > 1);
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);
  localparam logic [2:0] MEM_RELOAD   = FREEZE_EN ? 3'(MEM_LAT - 2) : 3'd0;

  state_e     state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic [2:0] mcnt_q, mcnt_d;

  logic [4:0] rs1, rs2;
  logic       rs2_used;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;
  logic       freeze_now;
  logic       unused_inst_bits;

  assign unused_inst_bits = ^{id_inst_i[31:25], id_inst_i[14:7]};

  // Decode of the IF/ID instruction and load-use detection.
  always_comb begin
    opcode_o = id_inst_i[6:4];
    rs1      = id_inst_i[19:15];
    rs2      = id_inst_i[24:20];
    valid_o  = 1'b0;
    rs2_used = 1'b0;
    unique case (id_inst_i[6:0])
      7'b0110011: begin valid_o = 1'b1; rs2_used = 1'b1; end
      7'b0100011: begin valid_o = 1'b1; rs2_used = 1'b1; end
      7'b1100011: begin valid_o = 1'b1; rs2_used = 1'b1; end
      7'b0010011: valid_o = 1'b1;
      7'b0000011: valid_o = 1'b1;
      default:    valid_o = 1'b0;
    endcase
    load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
               ((ex_rd_i == rs1) || (rs2_used && (ex_rd_i == rs2)));
  end

  // Next-state and control outputs; freeze outranks branch, branch outranks load-use.
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    mcnt_d        = mcnt_q;
    pc_write_o    = 1'b0;
    pc_sel_o      = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_en_o     = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    freeze_now    = 1'b0;

    if (!rst_i && start_i) begin
      if ((state_q != S_MEM_WAIT) && mem_access_i && FREEZE_EN) begin
        freeze_now = 1'b1;
        mcnt_d     = MEM_RELOAD;
        state_d    = S_MEM_WAIT;
      end else if ((state_q == S_MEM_WAIT) && (mcnt_q != 3'd0)) begin
        freeze_now = 1'b1;
        mcnt_d     = mcnt_q - 3'd1;
      end

      if (freeze_now) begin
        stall_inc = 1'b1;
      end else begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        pipe_en_o    = 1'b1;

        // Release cycle resumes any flush tail that the freeze interrupted.
        if (state_q == S_MEM_WAIT) begin
          state_d = (fcnt_q != 2'd0) ? S_FLUSH : S_RUN;
        end else if (state_q == S_FLUSH) begin
          ifid_flush_o = 1'b1;
          fcnt_d       = fcnt_q - 2'd1;
          state_d      = (fcnt_q == 2'd1) ? S_RUN : S_FLUSH;
        end

        if (branch_taken_i) begin
          pc_sel_o      = 1'b1;
          ifid_flush_o  = 1'b1;
          idex_bubble_o = 1'b1;
          fcnt_d        = FLUSH_RELOAD;
          state_d       = (FLUSH_RELOAD != 2'd0) ? S_FLUSH : S_RUN;
          flush_inc     = 1'b1;
        end else if (load_use) begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
          stall_inc     = 1'b1;
        end
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
      fcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counter next values; both wrap naturally.
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_inc);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_inc);
  end

  // Performance counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_cnt_inc;
  assign unused_cnt_inc = stall_inc ^ flush_inc;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl with FLUSH_DEPTH=3, MEM_LAT=3.
// Counter ports are checked when HAZARD_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam int FD = 3;
  localparam int ML = 3;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] LUI      = 32'h0000_0037;
  localparam logic [31:0] BEQ      = 32'h00A2_8263;
  localparam logic [31:0] ADD_RS1  = 32'h0012_8333; // add x6,x5,x1
  localparam logic [31:0] ADD_RS2  = 32'h0050_8333; // add x6,x1,x5
  localparam logic [31:0] ADDI_I5  = 32'h0050_8313; // addi x6,x1,5

  logic        clk = 1'b0;
  logic        rst, start, memread, mem_acc, br;
  logic [31:0] inst;
  logic [4:0]  ex_rd;
  logic [2:0]  opcode;
  logic        valid, pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, pipe_en;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int tests = 0;
  int fails = 0;

  pipe_hazard_ctrl #(.FLUSH_DEPTH(FD), .MEM_LAT(ML), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .id_inst_i(inst),
    .ex_memread_i(memread), .ex_rd_i(ex_rd), .mem_access_i(mem_acc),
    .branch_taken_i(br), .opcode_o(opcode), .valid_o(valid),
    .pc_write_o(pc_write), .pc_sel_o(pc_sel), .ifid_write_o(ifid_write),
    .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble), .pipe_en_o(pipe_en)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference rules, written from the instruction encoding.
  function automatic bit ref_uses_rs2(input logic [31:0] i);
    return (i[6:0] == 7'b0110011) || (i[6:0] == 7'b0100011) || (i[6:0] == 7'b1100011);
  endfunction

  function automatic bit ref_valid(input logic [31:0] i);
    return ref_uses_rs2(i) || (i[6:0] == 7'b0010011) || (i[6:0] == 7'b0000011);
  endfunction

  function automatic bit ref_load_use(input logic [31:0] i, input logic mr, input logic [4:0] rd);
    return mr && (rd != 5'd0) && ((rd == i[19:15]) || (ref_uses_rs2(i) && rd == i[24:20]));
  endfunction

  // Model state: cycles already frozen for the current access (-1 = none),
  // flush cycles still owed, and expected counter values.
  int acc_served = -1;
  int flush_owed = 0;
  int m_stall = 0;
  int m_flush = 0;
  // Observed pulse tallies used by the literal checks.
  int obs_flush = 0;
  int obs_psel  = 0;
  int obs_plow  = 0;

  bit e_pcw, e_psel, e_ifw, e_ifl, e_bub, e_pen, frozen;

  // Compare process: predicts and checks every output on each falling edge.
  always @(negedge clk) begin
    e_pcw = 0; e_psel = 0; e_ifw = 0; e_ifl = 0; e_bub = 0; e_pen = 0;
    chk("opcode", 32'(opcode), 32'(inst[6:4]));
    chk("valid", 32'(valid), 32'(ref_valid(inst)));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, rst ? 32'd0 : 32'(m_stall));
    chk("flush_cnt", flush_cnt, rst ? 32'd0 : 32'(m_flush));
`endif
    if (rst) begin
      acc_served = -1; flush_owed = 0; m_stall = 0; m_flush = 0;
    end else if (start) begin
      frozen = (acc_served < 0) ? (mem_acc && ML > 1) : (acc_served < ML - 1);
      if (frozen) begin
        acc_served = (acc_served < 0) ? 1 : acc_served + 1;
        m_stall++;
      end else begin
        e_pcw = 1; e_ifw = 1; e_pen = 1;
        if (acc_served >= 0) begin
          acc_served = -1;
        end else if (flush_owed > 0) begin
          e_ifl = 1;
          flush_owed--;
        end
        if (br) begin
          e_psel = 1; e_ifl = 1; e_bub = 1;
          flush_owed = FD - 1;
          m_flush++;
        end else if (ref_load_use(inst, memread, ex_rd)) begin
          e_pcw = 0; e_ifw = 0; e_bub = 1;
          m_stall++;
        end
      end
    end
    chk("pc_write", 32'(pc_write), 32'(e_pcw));
    chk("pc_sel", 32'(pc_sel), 32'(e_psel));
    chk("ifid_write", 32'(ifid_write), 32'(e_ifw));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_ifl));
    chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
    chk("pipe_en", 32'(pipe_en), 32'(e_pen));
    if (ifid_flush) obs_flush++;
    if (pc_sel) obs_psel++;
    if (!pipe_en && start && !rst) obs_plow++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int bf, bp, bl;

  initial begin
    rst = 1; start = 0; inst = NOP; memread = 0; ex_rd = '0; mem_acc = 0; br = 0;
    cyc();
    start = 1;
    #1 chk("rst_pipe_en", 32'(pipe_en), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    cyc(); rst = 0;
    cyc();
    #1 chk("run_pipe_en", 32'(pipe_en), 1);
    chk("run_pc_write", 32'(pc_write), 1);

    // Decode
    inst = LUI;
    #1 chk("lui_valid", 32'(valid), 0);
    chk("lui_opcode", 32'(opcode), 3'b011);
    inst = BEQ;
    #1 chk("beq_valid", 32'(valid), 1);
    chk("beq_opcode", 32'(opcode), 3'b110);

    // Load-use on rs1, then released
    cyc(); inst = ADD_RS1; memread = 1; ex_rd = 5'd5;
    #1 chk("lu_pc_write", 32'(pc_write), 0);
    chk("lu_ifid_write", 32'(ifid_write), 0);
    chk("lu_bubble", 32'(idex_bubble), 1);
    chk("lu_pipe_en", 32'(pipe_en), 1);
    cyc(); memread = 0;
    #1 chk("lu_after", 32'(pc_write), 1);
    cyc(); memread = 1; ex_rd = 5'd0;
    #1 chk("lu_x0", 32'(pc_write), 1);
    cyc(); inst = ADD_RS2; ex_rd = 5'd5;
    #1 chk("lu_rs2", 32'(pc_write), 0);
    cyc(); inst = ADDI_I5;
    #1 chk("lu_imm_not_rs2", 32'(idex_bubble), 0);
    cyc(); memread = 0; inst = NOP;

    // Taken branch: one select cycle, FD flush cycles
    bf = obs_flush; bp = obs_psel;
    br = 1;
    #1 chk("br_pc_sel", 32'(pc_sel), 1);
    cyc(); br = 0;
    #1 chk("br_tail", 32'(ifid_flush), 1);
    chk("br_tail_sel", 32'(pc_sel), 0);
    cyc(); cyc();
    #1 chk("br_done", 32'(ifid_flush), 0);
    chk("br_flush_cycles", 32'(obs_flush - bf), 3);
    chk("br_sel_cycles", 32'(obs_psel - bp), 1);
`ifdef HAZARD_PERF_CNT_EN
    chk("flush_cnt_lit", flush_cnt, 1);
`endif

    // Freeze: ML-1 frozen cycles then release
    cyc(); bl = obs_plow; mem_acc = 1;
    #1 chk("frz0", 32'(pipe_en), 0);
    cyc();
    #1 chk("frz1", 32'(pipe_en), 0);
    cyc();
    #1 chk("frz_release", 32'(pipe_en), 1);
    cyc(); mem_acc = 0;
    #1 chk("frz_after", 32'(pipe_en), 1);
    chk("frz_cycles", 32'(obs_plow - bl), 2);

    // Freeze with branch held: acted on only at release
    cyc(); bl = obs_plow; bp = obs_psel; mem_acc = 1; br = 1;
    #1 chk("fb_sel0", 32'(pc_sel), 0);
    cyc();
    #1 chk("fb_sel1", 32'(pc_sel), 0);
    cyc();
    #1 chk("fb_release_sel", 32'(pc_sel), 1);
    cyc(); mem_acc = 0; br = 0;
    #1 chk("fb_tail", 32'(ifid_flush), 1);
    cyc(); cyc();
    chk("fb_sel_cycles", 32'(obs_psel - bp), 1);
    chk("fb_frz_cycles", 32'(obs_plow - bl), 2);

    // Flush tail interrupted by a freeze
    br = 1;
    cyc(); br = 0; mem_acc = 1;
    cyc(); cyc(); cyc(); mem_acc = 0;
    repeat (4) cyc();

    // start_i low mid-flush holds the tail
    br = 1;
    cyc(); br = 0; start = 0;
    #1 chk("stop_pipe_en", 32'(pipe_en), 0);
    chk("stop_flush", 32'(ifid_flush), 0);
    cyc(); cyc(); start = 1;
    #1 chk("resume_flush", 32'(ifid_flush), 1);
    repeat (3) cyc();

    // Reset during the second frozen cycle
    mem_acc = 1;
    cyc(); rst = 1;
    #1 chk("rstfrz_pipe_en", 32'(pipe_en), 0);
    chk("rstfrz_pc_write", 32'(pc_write), 0);
    chk("rstfrz_ifid_write", 32'(ifid_write), 0);
    cyc(); rst = 0; mem_acc = 0;
    cyc();
    #1 chk("post_rst_pipe_en", 32'(pipe_en), 1);
    chk("post_rst_pc_write", 32'(pc_write), 1);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
